// File: rtl/toy_bus_req_sched_2to1.sv
// Two-to-one round-robin request scheduler with per-requester outstanding credits
// and zero-latency ack routing back to the requester that owns the ack tgt_id.
module toy_bus_req_sched_2to1 #(
  parameter int         REQ_PLD_W = 339,
  parameter int         ACK_PLD_W = 275,
  parameter int         MAX_OST   = 4,
  parameter logic [3:0] SRC_ID0   = 4'd0,
  parameter logic [3:0] SRC_ID1   = 4'd1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0_req_vld,
  output logic                 in0_req_rdy,
  input  logic [REQ_PLD_W-1:0] in0_req_pld,
  input  logic                 in1_req_vld,
  output logic                 in1_req_rdy,
  input  logic [REQ_PLD_W-1:0] in1_req_pld,
  output logic                 out_req_vld,
  input  logic                 out_req_rdy,
  output logic [REQ_PLD_W-1:0] out_req_pld,
  input  logic                 out_ack_vld,
  output logic                 out_ack_rdy,
  input  logic [ACK_PLD_W-1:0] out_ack_pld,
  input  logic [3:0]           out_ack_tgt_id,
  output logic                 in0_ack_vld,
  input  logic                 in0_ack_rdy,
  output logic [ACK_PLD_W-1:0] in0_ack_pld,
  output logic                 in1_ack_vld,
  input  logic                 in1_ack_rdy,
  output logic [ACK_PLD_W-1:0] in1_ack_pld,
  output logic [3:0]           ost_cnt0,
  output logic [3:0]           ost_cnt1,
  output logic                 err_sticky
);

  localparam logic [3:0] MAX_OST_C = 4'(MAX_OST);

  logic                 out_vld_q, out_vld_d;
  logic [REQ_PLD_W-1:0] out_pld_q, out_pld_d;
  logic                 ptr_q, ptr_d;
  logic [3:0]           cnt0_q, cnt0_d;
  logic [3:0]           cnt1_q, cnt1_d;
  logic                 err_q, err_d;

  logic load_en;
  logic cred0, cred1;
  logic elig0, elig1;
  logic pick0, pick1;
  logic gnt0, gnt1;
  logic sel0, sel1, unmatched;
  logic ack_hs0, ack_hs1;

  // Saturating credit update: simultaneous inc/dec cancel, decrement never wraps below 0.
  function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc,
                                          input logic dec);
    logic [3:0] r;
    r = cnt;
    if (inc && !dec) begin
      r = cnt + 4'd1;
    end else if (dec && !inc && (cnt != 4'd0)) begin
      r = cnt - 4'd1;
    end
    return r;
  endfunction

  function automatic logic cnt_underflow(input logic [3:0] cnt, input logic dec);
    return dec && (cnt == 4'd0);
  endfunction

  // ---- arbitration ----
  assign load_en = !out_vld_q || out_req_rdy;
  assign cred0   = (cnt0_q < MAX_OST_C);
  assign cred1   = (cnt1_q < MAX_OST_C);
  assign elig0   = in0_req_vld && cred0;
  assign elig1   = in1_req_vld && cred1;

  // pickI only looks at the other port's eligibility, so rdy never depends on its own vld
  assign pick0 = !ptr_q || !elig1;
  assign pick1 = ptr_q || !elig0;

  assign in0_req_rdy = load_en && cred0 && pick0;
  assign in1_req_rdy = load_en && cred1 && pick1;

  assign gnt0 = in0_req_vld && in0_req_rdy;
  assign gnt1 = in1_req_vld && in1_req_rdy;

  // ---- ack routing ----
  assign sel0      = (out_ack_tgt_id == SRC_ID0);
  assign sel1      = (out_ack_tgt_id == SRC_ID1);
  assign unmatched = out_ack_vld && !sel0 && !sel1;

  assign in0_ack_vld = out_ack_vld && sel0;
  assign in1_ack_vld = out_ack_vld && sel1 && !sel0;
  assign in0_ack_pld = out_ack_pld;
  assign in1_ack_pld = out_ack_pld;

  always_comb begin
    out_ack_rdy = 1'b1;
    if (sel0) begin
      out_ack_rdy = in0_ack_rdy;
    end else if (sel1) begin
      out_ack_rdy = in1_ack_rdy;
    end
  end

  assign ack_hs0 = in0_ack_vld && in0_ack_rdy;
  assign ack_hs1 = in1_ack_vld && in1_ack_rdy;

  // ---- next state ----
  always_comb begin
    out_vld_d = out_vld_q;
    out_pld_d = out_pld_q;
    ptr_d     = ptr_q;
    if (load_en) begin
      out_vld_d = gnt0 || gnt1;
      if (gnt0) begin
        out_pld_d = in0_req_pld;
      end else if (gnt1) begin
        out_pld_d = in1_req_pld;
      end
    end
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = 1'b0;
    end
  end

  always_comb begin
    cnt0_d = cnt_next(cnt0_q, gnt0, ack_hs0);
    cnt1_d = cnt_next(cnt1_q, gnt1, ack_hs1);
    err_d  = err_q || unmatched
           || cnt_underflow(cnt0_q, ack_hs0)
           || cnt_underflow(cnt1_q, ack_hs1);
  end

  // ---- state registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_pld_q <= '0;
      ptr_q     <= 1'b0;
      cnt0_q    <= 4'd0;
      cnt1_q    <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_pld_q <= out_pld_d;
      ptr_q     <= ptr_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      err_q     <= err_d;
    end
  end

  assign out_req_vld = out_vld_q;
  assign out_req_pld = out_pld_q;
  assign ost_cnt0    = cnt0_q;
  assign ost_cnt1    = cnt1_q;
  assign err_sticky  = err_q;

endmodule
